sdram_rr_arbiter: RTL

- Three-port arbiter that shares the single Avalon-MM SDRAM master between video read (R1), audio read (R2) and the SD-card loader write (W).
- Replaces stateless ack-steering with a fair scheduler: round-robin with a write-starvation guard, latched request capture, and ping-pong half protection.
- Sits between the peripheral request ports and the SDRAM controller's Avalon slave.

---
 rtl/sdram_rr_arbiter_pkg.sv | 42 ++++
 rtl/sdram_rr_arbiter_if.sv | 59 +++++
 rtl/sdram_rr_arbiter_rr_pick3.sv | 44 ++++
 rtl/sdram_rr_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sdram_rr_arbiter_pkg.sv
// Shared types and default sizes for the three-port SDRAM arbiter.
package sdram_arb_pkg;

    // Default geometry of the shared SDRAM port.
    localparam int ARB_ADDR_W      = 26;
    localparam int ARB_DATA_W      = 16;
    localparam int ARB_HALF_BIT    = 24;
    localparam int ARB_WR_MAX_WAIT = 64;

    // Arbiter FSM: wait for a request, own the bus, one idle gap cycle.
    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } arb_state_t;

    // Requester identity; also the round-robin order R1 -> R2 -> W.
    typedef enum logic [1:0] {
        P_R1,
        P_R2,
        P_W
    } port_id_t;

    // Requester that follows p in the round-robin ring.
    function automatic port_id_t next_port(input port_id_t p);
        case (p)
            P_R1:    next_port = P_R2;
            P_R2:    next_port = P_W;
            default: next_port = P_R1;
        endcase
    endfunction

    // One-hot winner {W, R2, R1} to requester id.
    function automatic port_id_t onehot_to_port(input logic [2:0] oh);
        case (oh)
            3'b010:  onehot_to_port = P_R2;
            3'b100:  onehot_to_port = P_W;
            default: onehot_to_port = P_R1;
        endcase
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter_if.sv
// Requester ports plus the Avalon-MM master side of the arbiter.
// The master modport is the arbiter's view; slave is the view of the
// requesters and the SDRAM controller around it.
interface sdram_rr_arbiter_if #(
    parameter int ADDR_W = sdram_arb_pkg::ARB_ADDR_W,
    parameter int DATA_W = sdram_arb_pkg::ARB_DATA_W
) ();

    // Video read port
    logic              r1_req;
    logic [ADDR_W-1:0] r1_addr;
    logic              r1_ack;
    logic [DATA_W-1:0] r1_rddata;

    // Audio read port
    logic              r2_req;
    logic [ADDR_W-1:0] r2_addr;
    logic              r2_ack;
    logic [DATA_W-1:0] r2_rddata;

    // SD-card loader write port
    logic              w_req;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_wrdata;
    logic              w_ack;
    logic              wr_half;

    // Avalon-MM towards the SDRAM controller
    logic [ADDR_W-1:0] avl_addr;
    logic              avl_read;
    logic              avl_write;
    logic [DATA_W-1:0] avl_wrdata;
    logic [DATA_W-1:0] avl_rddata;
    logic              avl_ack;

    // Sticky requester protocol violation
    logic              proto_err;

    modport master (
        input  r1_req, r1_addr, r2_req, r2_addr,
        input  w_req, w_addr, w_wrdata,
        input  avl_rddata, avl_ack,
        output r1_ack, r1_rddata, r2_ack, r2_rddata,
        output w_ack, wr_half,
        output avl_addr, avl_read, avl_write, avl_wrdata,
        output proto_err
    );

    modport slave (
        output r1_req, r1_addr, r2_req, r2_addr,
        output w_req, w_addr, w_wrdata,
        output avl_rddata, avl_ack,
        input  r1_ack, r1_rddata, r2_ack, r2_rddata,
        input  w_ack, wr_half,
        input  avl_addr, avl_read, avl_write, avl_wrdata,
        input  proto_err
    );

endinterface

// File: rtl/sdram_rr_arbiter_rr_pick3.sv
// Combinational three-way round-robin pick with a write override.
// Search starts at rr_ptr and walks R1 -> R2 -> W; force_w lets an
// eligible write jump the queue.
module rr_pick3
    import sdram_arb_pkg::*;
(
    input  logic [2:0] elig,     // {W, R2, R1}
    input  port_id_t   rr_ptr,
    input  logic       force_w,
    output logic [2:0] winner,   // one-hot {W, R2, R1}
    output logic       valid
);

    // Rotating priority search, overridden by the starvation guard.
    always_comb begin
        // NOTE: every output gets a default before any branch, so no path
        // leaves a value unassigned and no latch is inferred.
        winner = 3'b000;
        valid  = |elig;

        if (force_w && elig[2]) begin
            winner = 3'b100;
        end else begin
            case (rr_ptr)
                P_R2: begin
                    if      (elig[1]) winner = 3'b010;
                    else if (elig[2]) winner = 3'b100;
                    else if (elig[0]) winner = 3'b001;
                end
                P_W: begin
                    if      (elig[2]) winner = 3'b100;
                    else if (elig[0]) winner = 3'b001;
                    else if (elig[1]) winner = 3'b010;
                end
                default: begin
                    if      (elig[0]) winner = 3'b001;
                    else if (elig[1]) winner = 3'b010;
                    else if (elig[2]) winner = 3'b100;
                end
            endcase
        end
    end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Fair scheduler sharing one Avalon-MM SDRAM master between two read
// ports (video, audio) and the SD-card loader write port.
//  - Round-robin R1 -> R2 -> W, with a write-starvation guard.
//  - Winner's address/data captured at grant; requester changes ignored.
//  - The loader may only write the ping-pong half not being read.
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W      = ARB_ADDR_W,
    parameter int DATA_W      = ARB_DATA_W,
    parameter int HALF_BIT    = ARB_HALF_BIT,
    parameter int WR_MAX_WAIT = ARB_WR_MAX_WAIT
) (
    input  logic                clk50,
    input  logic                reset_n,
    sdram_rr_arbiter_if.master  bus
);

    localparam int              WAIT_W   = $clog2(WR_MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(WR_MAX_WAIT);

    arb_state_t        state_q,       state_d;
    port_id_t          rr_ptr_q,      rr_ptr_d;
    port_id_t          owner_q,       owner_d;
    logic              cur_rd_half_q, cur_rd_half_d;
    logic [WAIT_W-1:0] wr_wait_q,     wr_wait_d;
    logic [ADDR_W-1:0] addr_q,        addr_d;
    logic [DATA_W-1:0] wrdata_q,      wrdata_d;
    logic              proto_err_q,   proto_err_d;

    logic [2:0]        elig;
    logic              force_w;
    logic [2:0]        winner;
    logic              pick_valid;
    logic              arb_en;
    logic              grant;
    port_id_t          win_port;
    logic              in_grant;
    logic              owner_req;
    logic              ack_live;

    // A write is eligible only when it targets the half not being read.
    assign elig     = {bus.w_req && (bus.w_addr[HALF_BIT] != cur_rd_half_q),
                       bus.r2_req,
                       bus.r1_req};
    assign force_w  = elig[2] && (wr_wait_q >= WAIT_MAX);
    assign arb_en   = (state_q == IDLE) || (state_q == RELEASE);
    assign grant    = arb_en && pick_valid;
    assign win_port = onehot_to_port(winner);
    assign in_grant = (state_q == GRANT);
    assign ack_live = in_grant && bus.avl_ack;

    rr_pick3 u_pick (
        .elig    (elig),
        .rr_ptr  (rr_ptr_q),
        .force_w (force_w),
        .winner  (winner),
        .valid   (pick_valid)
    );

    // Current owner's request line, watched for early withdrawal.
    always_comb begin
        case (owner_q)
            P_R2:    owner_req = bus.r2_req;
            P_W:     owner_req = bus.w_req;
            default: owner_req = bus.r1_req;
        endcase
    end

    // Next-state, capture and half-tracking logic.
    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        owner_d       = owner_q;
        cur_rd_half_d = cur_rd_half_q;
        addr_d        = addr_q;
        wrdata_d      = wrdata_q;
        proto_err_d   = proto_err_q;

        case (state_q)
            IDLE, RELEASE: begin
                if (grant) begin
                    state_d  = GRANT;
                    owner_d  = win_port;
                    rr_ptr_d = next_port(win_port);
                    case (win_port)
                        P_R1: begin
                            addr_d        = bus.r1_addr;
                            cur_rd_half_d = bus.r1_addr[HALF_BIT];
                        end
                        P_R2: begin
                            addr_d        = bus.r2_addr;
                            cur_rd_half_d = bus.r2_addr[HALF_BIT];
                        end
                        default: begin
                            addr_d   = bus.w_addr;
                            wrdata_d = bus.w_wrdata;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                // Strobe stays up regardless of req; only avl_ack ends it.
                if (!owner_req && !bus.avl_ack) begin
                    proto_err_d = 1'b1;
                end
                if (bus.avl_ack) begin
                    state_d = RELEASE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Write starvation counter: counts cycles an eligible write is refused.
    always_comb begin
        wr_wait_d = wr_wait_q;
        if (!elig[2] || (grant && (win_port == P_W))) begin
            wr_wait_d = '0;
        end else if (in_grant && (owner_q == P_W)) begin
            wr_wait_d = wr_wait_q;
        end else if (wr_wait_q < WAIT_MAX) begin
            wr_wait_d = wr_wait_q + 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk50 or negedge reset_n) begin
        // NOTE: every register here, including captured addr/data, has a
        // reset value, so outputs are defined the instant reset asserts.
        if (!reset_n) begin
            state_q       <= IDLE;
            rr_ptr_q      <= P_R1;
            owner_q       <= P_R1;
            cur_rd_half_q <= 1'b1;
            wr_wait_q     <= '0;
            addr_q        <= '0;
            wrdata_q      <= '0;
            proto_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so all flops update together
            // from the values of the previous cycle.
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            owner_q       <= owner_d;
            cur_rd_half_q <= cur_rd_half_d;
            wr_wait_q     <= wr_wait_d;
            addr_q        <= addr_d;
            wrdata_q      <= wrdata_d;
            proto_err_q   <= proto_err_d;
        end
    end

    // Bus outputs: strobes from state, acks combinational from avl_ack.
    assign bus.avl_read   = in_grant && (owner_q != P_W);
    assign bus.avl_write  = in_grant && (owner_q == P_W);
    assign bus.avl_addr   = addr_q;
    assign bus.avl_wrdata = wrdata_q;

    assign bus.r1_ack     = ack_live && (owner_q == P_R1);
    assign bus.r2_ack     = ack_live && (owner_q == P_R2);
    assign bus.w_ack      = ack_live && (owner_q == P_W);
    assign bus.r1_rddata  = bus.r1_ack ? bus.avl_rddata : '0;
    assign bus.r2_rddata  = bus.r2_ack ? bus.avl_rddata : '0;

    assign bus.wr_half    = ~cur_rd_half_q;
    assign bus.proto_err  = proto_err_q;

endmodule
